// File: rtl/tdm_demux8.sv
`default_nettype none
// ============================================================================
// Module   : tdm_demux8
// Brief    : 1-to-8 TDM demultiplexer; collects one 8-slot frame into a shadow
//            register and commits all channels at once with a strobe.
// Revision : 1.0 - initial release
// ============================================================================
module tdm_demux8 #(
    parameter bit SYNC_REQ = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       din,
    input  logic       din_valid,
    input  logic       frame_sync,
    output logic [7:0] y,
    output logic       frame_valid,
    output logic       sync_err,
    output logic       locked
);

    typedef enum logic [0:0] {
        S_HUNT = 1'b0,
        S_RECV = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [2:0] r_cnt;
    logic [2:0] w_cnt_nxt;
    // Slot 7 never needs storing: it goes straight into y on commit.
    logic [6:0] r_shadow;
    logic [6:0] w_shadow_nxt;
    logic [7:0] r_y;
    logic [7:0] w_y_nxt;
    logic       r_frame_valid;
    logic       w_frame_valid_nxt;
    logic       r_sync_err;
    logic       w_sync_err_nxt;
    logic       r_locked;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_HUNT;
            r_cnt         <= 3'd0;
            r_shadow      <= 7'd0;
            r_y           <= 8'h00;
            r_frame_valid <= 1'b0;
            r_sync_err    <= 1'b0;
            r_locked      <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_shadow      <= w_shadow_nxt;
            r_y           <= w_y_nxt;
            r_frame_valid <= w_frame_valid_nxt;
            r_sync_err    <= w_sync_err_nxt;
            r_locked      <= (w_state_nxt == S_RECV);
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_cnt_nxt         = r_cnt;
        w_shadow_nxt      = r_shadow;
        w_y_nxt           = r_y;
        w_frame_valid_nxt = 1'b0;
        w_sync_err_nxt    = 1'b0;

        if (din_valid) begin
            case (r_state)
                S_HUNT: begin
                    if (frame_sync) begin
                        w_shadow_nxt[0] = din;
                        w_cnt_nxt       = 3'd1;
                        w_state_nxt     = S_RECV;
                    end
                end
                S_RECV: begin
                    if (frame_sync) begin
                        // A sync anywhere but slot 0 restarts the frame; stale shadow bits get overwritten.
                        w_sync_err_nxt  = (r_cnt != 3'd0);
                        w_shadow_nxt[0] = din;
                        w_cnt_nxt       = 3'd1;
                    end else if (r_cnt == 3'd0) begin
                        if (SYNC_REQ) begin
                            w_sync_err_nxt = 1'b1;
                            w_state_nxt    = S_HUNT;
                        end else begin
                            w_shadow_nxt[0] = din;
                            w_cnt_nxt       = 3'd1;
                        end
                    end else if (r_cnt == 3'd7) begin
                        w_y_nxt           = {din, r_shadow};
                        w_frame_valid_nxt = 1'b1;
                        w_cnt_nxt         = 3'd0;
                    end else begin
                        for (int k = 1; k < 7; k++) begin
                            if (r_cnt == 3'(k)) begin
                                w_shadow_nxt[k] = din;
                            end
                        end
                        w_cnt_nxt = r_cnt + 3'd1;
                    end
                end
                default: begin
                    w_state_nxt = S_HUNT;
                    w_cnt_nxt   = 3'd0;
                end
            endcase
        end
    end

    assign y           = r_y;
    assign frame_valid = r_frame_valid;
    assign sync_err    = r_sync_err;
    assign locked      = r_locked;

endmodule
`default_nettype wire

// File: tb/tb_tdm_demux8.sv
`default_nettype none
// ============================================================================
// Module   : tb_tdm_demux8
// Brief    : Self-checking bench; drives SYNC_REQ=1 (a) and SYNC_REQ=0 (b)
//            instances in parallel against a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tdm_demux8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       din = 1'b0;
    logic       din_valid = 1'b0;
    logic       frame_sync = 1'b0;
    logic [7:0] y_a, y_b;
    logic       fv_a, fv_b, err_a, err_b, lk_a, lk_b;

    int total = 0;
    int bad = 0;
    int fv_cnt[2];
    int err_cnt[2];

    always #5 clk = ~clk;

    tdm_demux8 #(.SYNC_REQ(1'b1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .frame_sync(frame_sync),
        .y(y_a), .frame_valid(fv_a), .sync_err(err_a), .locked(lk_a)
    );

    tdm_demux8 #(.SYNC_REQ(1'b0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .frame_sync(frame_sync),
        .y(y_b), .frame_valid(fv_b), .sync_err(err_b), .locked(lk_b)
    );

    // Reference model: a bit list per instance, committed when it reaches 8 entries.
    bit         m_lock[2];
    int         m_n[2];
    bit   [7:0] m_bits[2];
    bit   [7:0] m_y[2];
    bit         m_fv[2];
    bit         m_err[2];

    task automatic model_step(input int n, input bit sreq);
        m_fv[n]  = 1'b0;
        m_err[n] = 1'b0;
        if (din_valid) begin
            if (!m_lock[n]) begin
                if (frame_sync) begin
                    m_lock[n] = 1'b1;
                    m_bits[n] = 8'h00;
                    m_bits[n][0] = din;
                    m_n[n] = 1;
                end
            end else if (frame_sync) begin
                if (m_n[n] != 0) m_err[n] = 1'b1;
                m_bits[n] = 8'h00;
                m_bits[n][0] = din;
                m_n[n] = 1;
            end else if (m_n[n] == 0 && sreq) begin
                m_err[n]  = 1'b1;
                m_lock[n] = 1'b0;
            end else begin
                m_bits[n][m_n[n]] = din;
                m_n[n] = m_n[n] + 1;
                if (m_n[n] == 8) begin
                    m_y[n]  = m_bits[n];
                    m_fv[n] = 1'b1;
                    m_n[n]  = 0;
                end
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < 2; n++) begin
                m_lock[n] = 1'b0; m_n[n] = 0; m_bits[n] = 8'h00;
                m_y[n] = 8'h00; m_fv[n] = 1'b0; m_err[n] = 1'b0;
            end
        end else begin
            model_step(0, 1'b1);
            model_step(1, 1'b0);
        end
    end

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("a.y", y_a, m_y[0]);
        check("a.frame_valid", {7'd0, fv_a}, {7'd0, m_fv[0]});
        check("a.sync_err", {7'd0, err_a}, {7'd0, m_err[0]});
        check("a.locked", {7'd0, lk_a}, {7'd0, m_lock[0]});
        check("b.y", y_b, m_y[1]);
        check("b.frame_valid", {7'd0, fv_b}, {7'd0, m_fv[1]});
        check("b.sync_err", {7'd0, err_b}, {7'd0, m_err[1]});
        check("b.locked", {7'd0, lk_b}, {7'd0, m_lock[1]});
        check("a.fv_and_err", {7'd0, fv_a & err_a}, 8'd0);
        check("b.fv_and_err", {7'd0, fv_b & err_b}, 8'd0);
        if (fv_a)  fv_cnt[0]++;
        if (fv_b)  fv_cnt[1]++;
        if (err_a) err_cnt[0]++;
        if (err_b) err_cnt[1]++;
    end

    task automatic put(input logic v, input logic s, input logic d);
        @(negedge clk);
        din_valid  = v;
        frame_sync = s;
        din        = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) put(1'b0, 1'b0, 1'b0);
    endtask

    task automatic settle();
        idle(2);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] v, input logic with_sync, input int gap2, input int gap5);
        for (int k = 0; k < 8; k++) begin
            put(1'b1, with_sync && (k == 0), v[k]);
            if (k == 2) idle(gap2);
            if (k == 5) idle(gap5);
        end
    endtask

    int fa, fb, ea, eb;

    task automatic snap();
        fa = fv_cnt[0]; fb = fv_cnt[1]; ea = err_cnt[0]; eb = err_cnt[1];
    endtask

    initial begin
        fv_cnt[0] = 0; fv_cnt[1] = 0; err_cnt[0] = 0; err_cnt[1] = 0;

        // Reset state
        idle(3);
        #1;
        check("rst.y_a", y_a, 8'h00);
        check("rst.locked_a", {7'd0, lk_a}, 8'd0);
        check("rst.fv_a", {7'd0, fv_a}, 8'd0);
        check("rst.y_b", y_b, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // Single frame A5 (slots 1,0,1,0,0,1,0,1)
        send_frame(8'hA5, 1'b1, 0, 0);
        idle(1);
        #1;
        check("f1.y_a", y_a, 8'hA5);
        check("f1.fv_a", {7'd0, fv_a}, 8'd1);
        check("f1.locked_a", {7'd0, lk_a}, 8'd1);
        check("f1.err_a", {7'd0, err_a}, 8'd0);
        check("f1.y_b", y_b, 8'hA5);
        idle(1);
        #1;
        check("f1.fv_a_drop", {7'd0, fv_a}, 8'd0);
        settle();

        // Back-to-back frames with valid gaps
        snap();
        send_frame(8'hA5, 1'b1, 2, 2);
        send_frame(8'h3C, 1'b1, 2, 2);
        settle();
        check("b2b.y_a", y_a, 8'h3C);
        check("b2b.fv_pulses_a", 8'(fv_cnt[0] - fa), 8'd2);
        check("b2b.err_pulses_a", 8'(err_cnt[0] - ea), 8'd0);

        // No lock before frame_sync
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        settle();
        snap();
        for (int i = 0; i < 10; i++) put(1'b1, 1'b0, 1'(i & 1));
        settle();
        check("hunt.y_a", y_a, 8'h00);
        check("hunt.y_b", y_b, 8'h00);
        check("hunt.locked_b", {7'd0, lk_b}, 8'd0);
        check("hunt.pulses_b", 8'(fv_cnt[1] - fb + err_cnt[1] - eb), 8'd0);
        send_frame(8'hFF, 1'b1, 0, 0);
        settle();
        check("ff.y_a", y_a, 8'hFF);
        check("ff.y_b", y_b, 8'hFF);

        // Early sync after 4 slots
        snap();
        put(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) put(1'b1, 1'b0, 1'b0);
        send_frame(8'h0F, 1'b1, 0, 0);
        settle();
        check("early.err_a", 8'(err_cnt[0] - ea), 8'd1);
        check("early.err_b", 8'(err_cnt[1] - eb), 8'd1);
        check("early.fv_a", 8'(fv_cnt[0] - fa), 8'd1);
        check("early.y_a", y_a, 8'h0F);
        check("early.y_b", y_b, 8'h0F);

        // Missing sync on the next slot 0
        send_frame(8'hA5, 1'b1, 0, 0);
        settle();
        snap();
        send_frame(8'h81, 1'b0, 0, 0);
        settle();
        check("miss.y_a", y_a, 8'hA5);
        check("miss.locked_a", {7'd0, lk_a}, 8'd0);
        check("miss.err_a", 8'(err_cnt[0] - ea), 8'd1);
        check("miss.y_b", y_b, 8'h81);
        check("miss.err_b", 8'(err_cnt[1] - eb), 8'd0);
        check("miss.locked_b", {7'd0, lk_b}, 8'd1);

        // Asynchronous reset mid-frame
        snap();
        put(1'b1, 1'b1, 1'b0);
        for (int i = 1; i < 4; i++) put(1'b1, 1'b0, 1'b1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.y_a", y_a, 8'h00);
        check("arst.locked_a", {7'd0, lk_a}, 8'd0);
        check("arst.y_b", y_b, 8'h00);
        check("arst.locked_b", {7'd0, lk_b}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 4; i < 8; i++) put(1'b1, 1'b0, 1'b1);
        settle();
        check("arst.after_y_b", y_b, 8'h00);
        check("arst.after_locked_b", {7'd0, lk_b}, 8'd0);
        check("arst.after_fv_b", 8'(fv_cnt[1] - fb), 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
